// File: rtl/rom_responder.sv
// rom_responder: bus-side ROM responder for a 4-bit CPU with a multiplexed
// instruction/data bus. It follows the 8-phase machine cycle
// (A1 A2 A3 M1 M2 X1 X2 X3) and latches the 12-bit address. When the A3
// nibble matches CHIP_ID it returns the addressed opcode as two nibbles in
// M1 and M2. It also snoops SRC, WRR and RDR to serve a 4-bit I/O port.
//
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   sync                    marks the A1 clock of every machine cycle
//   cm_rom                  CPU ROM command line (M2/X2 of I/O ops and SRC)
//   data_in                 bus nibble driven by the CPU
//   data_out, data_oe       nibble driven back onto the bus, and its enable
//   io_in, io_out           I/O port input pins and registered output latch
//   prog_we/addr/data       ROM load port (256 x 8)
module rom_responder #(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sync,
    input  logic       cm_rom,
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_oe,
    input  logic [3:0] io_in,
    output logic [3:0] io_out,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data
);

    typedef enum logic [2:0] {
        PhA1 = 3'd0,
        PhA2 = 3'd1,
        PhA3 = 3'd2,
        PhM1 = 3'd3,
        PhM2 = 3'd4,
        PhX1 = 3'd5,
        PhX2 = 3'd6,
        PhX3 = 3'd7
    } phase_e;

    localparam logic [3:0] OpWrr = 4'h2;
    localparam logic [3:0] OpRdr = 4'hA;

    phase_e     phase_q, phase_d, cur_phase;
    logic       valid_q, valid_d, cur_valid;
    logic       abort;
    logic [2:0] phase_inc;

    logic [7:0] rom_mem [256];
    logic [3:0] addr_lo_q, addr_mid_q;
    logic [7:0] opcode_q;
    logic       sel_q;
    logic       src_pend_q;
    logic       io_op_vld_q;
    logic [3:0] io_op_q;
    logic       io_sel_q;
    logic [3:0] io_out_q;

    // ROM storage is never reset so its contents survive a bus reset.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            rom_mem[prog_addr] <= prog_data;
        end
    end

    // sync overrides the tracked phase: the current clock is A1 regardless.
    always_comb begin
        cur_valid = sync | valid_q;
        cur_phase = sync ? PhA1 : phase_q;
        abort     = sync & valid_q & (phase_q != PhA1);
    end

    // Phase state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            phase_q <= PhA1;
        end else begin
            valid_q <= valid_d;
            phase_q <= phase_d;
        end
    end

    // Next phase; X3 + 1 wraps to A1 so free-running cycles need no sync.
    always_comb begin
        phase_inc = cur_phase + 3'd1;
        valid_d   = cur_valid;
        phase_d   = phase_e'(phase_inc);
    end

    // Address capture and opcode fetch. The fetch reads the array with a
    // non-blocking assignment, so a write on the same edge is not seen.
    always_ff @(posedge clock) begin
        if (cur_valid) begin
            if (cur_phase == PhA1) addr_lo_q  <= data_in;
            if (cur_phase == PhA2) addr_mid_q <= data_in;
            if (cur_phase == PhA3) opcode_q   <= rom_mem[{addr_mid_q, addr_lo_q}];
        end
    end

    // Chip select, pending I/O decode and I/O port state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sel_q       <= 1'b0;
            src_pend_q  <= 1'b0;
            io_op_vld_q <= 1'b0;
            io_op_q     <= 4'h0;
            io_sel_q    <= 1'b0;
            io_out_q    <= 4'h0;
        end else if (cur_valid) begin
            // An aborted cycle must not complete its pending I/O action.
            if (abort) begin
                src_pend_q  <= 1'b0;
                io_op_vld_q <= 1'b0;
            end
            case (cur_phase)
                PhA3: sel_q <= (data_in == CHIP_ID);
                PhM2: begin
                    // SRC may address another chip's port, so no sel here.
                    src_pend_q  <= cm_rom && (opcode_q[7:4] == 4'h2) && opcode_q[0];
                    io_op_vld_q <= sel_q && cm_rom && (opcode_q[7:4] == 4'hE);
                    io_op_q     <= opcode_q[3:0];
                end
                PhX2: begin
                    if (src_pend_q && cm_rom) begin
                        io_sel_q <= (data_in == CHIP_ID);
                    end
                    if (io_op_vld_q && (io_op_q == OpWrr) && io_sel_q) begin
                        io_out_q <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus drive: M1/M2 opcode nibbles when selected, X2 port read for RDR.
    always_comb begin
        data_oe  = 1'b0;
        data_out = 4'h0;
        if (cur_valid) begin
            case (cur_phase)
                PhM1: begin
                    if (sel_q) begin
                        data_oe  = 1'b1;
                        data_out = opcode_q[7:4];
                    end
                end
                PhM2: begin
                    if (sel_q) begin
                        data_oe  = 1'b1;
                        data_out = opcode_q[3:0];
                    end
                end
                PhX2: begin
                    if (io_op_vld_q && (io_op_q == OpRdr) && io_sel_q) begin
                        data_oe  = 1'b1;
                        data_out = io_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_out = io_out_q;

endmodule
